pdi_block_sequencer: RTL

Upstream feeder for `padding_mux` in the protected Romulus datapath. It parses the 32-bit LWC segment header from the PDI stream, then splits the segment into 128-bit blocks of `BUSW`-bit words. For each word it drives the `cnt`, `seglen`, `pad` and `last` controls `padding_mux` needs. For a short final block it inserts synthetic zero words, without consuming PDI input, until the block is complete.

---
 rtl/pdi_block_sequencer_pkg.sv | 25 ++
 rtl/pdi_skid_buffer.sv | 48 ++++
 rtl/pdi_block_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pdi_block_sequencer_pkg.sv
// pdi_block_sequencer_pkg
//   Shared constants for the PDI block sequencer:
//   - the bit positions of the LWC segment header fields,
//   - the sequencer state encoding,
//   - a helper that consumes one word's worth of the remaining byte count.
package pdi_block_sequencer_pkg;

  // Segment header field positions. Bits 23:16 carry nothing the sequencer uses.
  localparam int HDR_TYPE_HI = 31;
  localparam int HDR_TYPE_LO = 28;
  localparam int HDR_EOT     = 25;
  localparam int HDR_LEN_HI  = 15;
  localparam int HDR_LEN_LO  = 0;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a segment header
  localparam logic [1:0] ST_DATA = 2'd1;  // forwarding PDI data words
  localparam logic [1:0] ST_PADW = 2'd2;  // emitting synthetic zero words

  // Byte count left after one 4-byte word (saturates at zero).
  function automatic logic [15:0] sub_word(input logic [15:0] rem);
    return (rem > 16'd4) ? rem - 16'd4 : 16'd0;
  endfunction

endpackage

// File: rtl/pdi_skid_buffer.sv
// pdi_skid_buffer
//   Two-entry register FIFO placed on the sequencer output when
//   ROMULUS_PDI_OUT_REG_EN is defined. in_ready_o depends only on occupancy,
//   so the upstream ready is cut from the downstream ready. Two entries keep
//   full throughput with a one-cycle latency.
//   Ports: clk, rst (async, active high), in_* (write side), out_* (read side).
`ifdef ROMULUS_PDI_OUT_REG_EN
module pdi_skid_buffer #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  logic [1:0][W-1:0] mem_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;
  logic              wr, rd;

  assign in_ready_o  = (occ_q != 2'd2);
  assign out_valid_o = (occ_q != 2'd0);
  // Empty buffer presents zeros so idle outputs stay quiet.
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign wr          = in_valid_i & in_ready_o;
  assign rd          = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule
`endif

// File: rtl/pdi_block_sequencer.sv
// pdi_block_sequencer
//   Parses the 32-bit LWC segment header from the PDI stream and splits the
//   segment into 128-bit blocks of BUSW-bit words for padding_mux. A short
//   final block is completed with synthetic zero words that consume no PDI
//   input.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     pdi_data/pdi_valid/pdi_ready  header and data words in
//     word_data/word_valid/word_ready  words out to the core
//     cnt, seglen, pad, last        per-word block controls for padding_mux
//     blk_end                       handshake on the 4th word of a block
//     seg_done                      one-cycle pulse after a segment's last word
//     seg_type, seg_eot             latched header type and EOT
//   Build option: ROMULUS_PDI_OUT_REG_EN registers every word-side output
//   through pdi_skid_buffer (1-cycle latency, full throughput).
module pdi_block_sequencer
  import pdi_block_sequencer_pkg::*;
#(
  parameter int BUSW = 32,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BUSW-1:0] pdi_data,
  input  logic            pdi_valid,
  output logic            pdi_ready,
  output logic [BUSW-1:0] word_data,
  output logic            word_valid,
  input  logic            word_ready,
  output logic [CNTW-1:0] cnt,
  output logic [3:0]      seglen,
  output logic            pad,
  output logic            last,
  output logic            blk_end,
  output logic            seg_done,
  output logic [3:0]      seg_type,
  output logic            seg_eot
);
  localparam logic [CNTW-1:0] CNT_LAST = {CNTW{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [15:0]     rem_q, rem_d, blk_rem_q, blk_rem_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      seg_type_q;
  logic            seg_eot_q, seg_done_q, seg_done_d;

  // Sequencer-side word stream, before the optional output register.
  logic            s_valid, s_ready, s_hs, s_pad, s_last;
  logic [BUSW-1:0] s_data;
  logic [3:0]      s_seglen;
  logic            pdi_rdy, hdr_hs, final_word;
  logic [15:0]     rem_nx, hdr_len;

  assign hdr_len = pdi_data[HDR_LEN_HI:HDR_LEN_LO];
  assign rem_nx  = sub_word(rem_q);

  always_comb begin
    s_valid = 1'b0;
    s_data  = '0;
    pdi_rdy = 1'b0;
    case (state_q)
      ST_IDLE: pdi_rdy = 1'b1;
      ST_DATA: begin
        s_valid = pdi_valid;
        s_data  = pdi_data;
        pdi_rdy = s_ready;
      end
      ST_PADW: s_valid = 1'b1;
      default: ;
    endcase
  end

  assign s_hs   = s_valid & s_ready;
  assign hdr_hs = (state_q == ST_IDLE) & pdi_valid;
  // Held in reset, the port must not advertise readiness.
  assign pdi_ready = ~rst & pdi_rdy;

  // Block controls come from blk_rem, which only moves at block boundaries,
  // so they hold for all four words of a block. Quiet while idle.
  assign s_pad    = (state_q != ST_IDLE) && (blk_rem_q < 16'd16);
  assign s_seglen = s_pad ? blk_rem_q[3:0] : 4'd0;
  assign s_last   = s_pad && (cnt_q == CNT_LAST);

  // Word that closes the segment: 4th word of a block with nothing left.
  assign final_word = (cnt_q == CNT_LAST) &&
                      ((state_q == ST_PADW) || ((state_q == ST_DATA) && (rem_nx == 16'd0)));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    blk_rem_d = blk_rem_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (pdi_valid) begin
        rem_d     = hdr_len;
        blk_rem_d = hdr_len;
        cnt_d     = '0;
        state_d   = (hdr_len != 16'd0) ? ST_DATA : ST_PADW;
      end
      ST_DATA: if (s_hs) begin
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) blk_rem_d = rem_nx;
        if (rem_nx == 16'd0) state_d = (cnt_q == CNT_LAST) ? ST_IDLE : ST_PADW;
      end
      ST_PADW: if (s_hs) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      blk_rem_q  <= '0;
      cnt_q      <= '0;
      seg_type_q <= '0;
      seg_eot_q  <= 1'b0;
      seg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      blk_rem_q  <= blk_rem_d;
      cnt_q      <= cnt_d;
      seg_done_q <= seg_done_d;
      if (hdr_hs) begin
        seg_type_q <= pdi_data[HDR_TYPE_HI:HDR_TYPE_LO];
        seg_eot_q  <= pdi_data[HDR_EOT];
      end
    end
  end

  assign seg_done = seg_done_q;
  assign seg_type = seg_type_q;
  assign seg_eot  = seg_eot_q;

`ifdef ROMULUS_PDI_OUT_REG_EN
  // Payload: data, cnt, seglen, pad, last, 4th-word flag, segment-final flag.
  localparam int PW = BUSW + CNTW + 8;
  logic [PW-1:0] sk_in, sk_out;
  logic          o_end, o_final;

  assign sk_in = {s_data, cnt_q, s_seglen, s_pad, s_last, (cnt_q == CNT_LAST), final_word};

  pdi_skid_buffer #(.W(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (sk_in),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .out_data_o  (sk_out),
    .out_valid_o (word_valid),
    .out_ready_i (word_ready)
  );

  assign {word_data, cnt, seglen, pad, last, o_end, o_final} = sk_out;
  assign blk_end    = word_valid & word_ready & o_end;
  // Segment completion is reported when its last word leaves the buffer.
  assign seg_done_d = word_valid & word_ready & o_final;
`else
  assign s_ready    = word_ready;
  assign word_valid = s_valid;
  assign word_data  = s_data;
  assign cnt        = cnt_q;
  assign seglen     = s_seglen;
  assign pad        = s_pad;
  assign last       = s_last;
  assign blk_end    = s_hs & (cnt_q == CNT_LAST);
  assign seg_done_d = s_hs & final_word;
`endif

endmodule
